// File: rtl/md_divider_pkg.sv
// rtl/md_divider_pkg.sv - shared state encodings, default width and DIV/DIVU function codes
// Imported by md_divider and md_div_step; the execute stage uses the function codes to drive is_signed.
package md_divider_pkg;

   localparam int DIV_WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      DIVST_IDLE = 2'd0,
      DIVST_CALC = 2'd1,
      DIVST_FIX  = 2'd2,
      DIVST_DONE = 2'd3
   } div_state_e;

   localparam logic [5:0] FUNCT_DIV  = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU = 6'h1B;

   function automatic logic funct_is_signed_div(input logic [5:0] funct);
      return funct == FUNCT_DIV;
   endfunction

endpackage

// File: rtl/md_div_step.sv
// rtl/md_div_step.sv - one combinational radix-2 restoring-division iteration
// Shifts {rem, q} left by one and keeps the trial subtraction when it does not go negative.
module md_div_step
   import md_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // rem < divisor holds on entry, so the trial always fits in WIDTH+1 bits
   assign shifted = {rem_i, q_i[WIDTH-1]};
   assign trial   = shifted - {1'b0, divisor_i};

   assign rem_o = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   assign q_o   = {q_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/md_divider.sv
// rtl/md_divider.sv - iterative radix-2 restoring divider producing LO (quotient) and HI (remainder)
// Optional MD_DIV_CANCEL_EN adds a cancel port that aborts an operation in CALC or FIX.
module md_divider
   import md_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef MD_DIV_CANCEL_EN
   input  logic             cancel,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sgn_q, sgn_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;
   logic [WIDTH-1:0] quot_out_q, quot_out_d;
   logic [WIDTH-1:0] rem_out_q, rem_out_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_q;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   // 0x80000000 negates to itself, which is the correct unsigned magnitude
   assign dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
   assign dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

   assign q_fix = (sgn_q && qneg_q) ? -quo_q : quo_q;
   assign r_fix = (sgn_q && rneg_q) ? -rem_q : rem_q;

   md_div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem_i    (rem_q),
      .q_i      (quo_q),
      .divisor_i(dvs_q),
      .rem_o    (step_rem),
      .q_o      (step_q)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sgn_d      = sgn_q;
      qneg_d     = qneg_q;
      rneg_d     = rneg_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      dvs_d      = dvs_q;
      dvd_raw_d  = dvd_raw_q;
      quot_out_d = quot_out_q;
      rem_out_d  = rem_out_q;
      dbz_d      = dbz_q;

      case (state_q)
         DIVST_IDLE: begin
            if (start) begin
               sgn_d     = is_signed;
               qneg_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               rneg_d    = dividend[WIDTH-1];
               quo_d     = dvd_mag;
               dvs_d     = dvs_mag;
               dvd_raw_d = dividend;
               rem_d     = '0;
               cnt_d     = '0;
               state_d   = DIVST_CALC;
            end
         end
         DIVST_CALC: begin
            rem_d = step_rem;
            quo_d = step_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = DIVST_FIX;
            end
         end
         DIVST_FIX: begin
            // the divisor magnitude is zero exactly when the divisor was zero
            if (dvs_q == '0) begin
               quot_out_d = '1;
               rem_out_d  = dvd_raw_q;
               dbz_d      = 1'b1;
            end else begin
               quot_out_d = q_fix;
               rem_out_d  = r_fix;
               dbz_d      = 1'b0;
            end
            state_d = DIVST_DONE;
         end
         DIVST_DONE: begin
            state_d = DIVST_IDLE;
         end
         default: begin
            state_d = DIVST_IDLE;
         end
      endcase

`ifdef MD_DIV_CANCEL_EN
      if (cancel && (state_q == DIVST_CALC || state_q == DIVST_FIX)) begin
         state_d    = DIVST_IDLE;
         quot_out_d = quot_out_q;
         rem_out_d  = rem_out_q;
         dbz_d      = dbz_q;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= DIVST_IDLE;
         cnt_q      <= '0;
         sgn_q      <= 1'b0;
         qneg_q     <= 1'b0;
         rneg_q     <= 1'b0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         dvd_raw_q  <= '0;
         quot_out_q <= '0;
         rem_out_q  <= '0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sgn_q      <= sgn_d;
         qneg_q     <= qneg_d;
         rneg_q     <= rneg_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvs_q      <= dvs_d;
         dvd_raw_q  <= dvd_raw_d;
         quot_out_q <= quot_out_d;
         rem_out_q  <= rem_out_d;
         dbz_q      <= dbz_d;
      end
   end

   assign busy        = (state_q != DIVST_IDLE);
   assign done        = (state_q == DIVST_DONE);
   assign quotient    = quot_out_q;
   assign remainder   = rem_out_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_md_divider.sv
// tb/tb_md_divider.sv - directed self-checking bench for md_divider (WIDTH=32)
// Cycle n is the clock period whose closing edge is edge n; the start edge is edge 0.
module tb_md_divider;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
`ifdef MD_DIV_CANCEL_EN
   logic        cancel;
`endif
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int tests = 0;
   int fails = 0;

   md_divider #(
      .WIDTH(32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .is_signed  (is_signed),
      .dividend   (dividend),
      .divisor    (divisor),
`ifdef MD_DIV_CANCEL_EN
      .cancel     (cancel),
`endif
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start in the current cycle, then check busy/done every cycle and the result in cycle 34.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq,
                          input logic [31:0] er, input logic edbz);
      is_signed = sgn;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      step();
      start     = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      is_signed = 1'($urandom_range(0, 1));
      for (int c = 1; c <= 34; c++) begin
         check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'd1);
         check($sformatf("%s done c%0d", tag, c), 32'(done), 32'(c == 34));
         if (c == 34) begin
            check({tag, " quotient"}, quotient, eq);
            check({tag, " remainder"}, remainder, er);
            check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edbz));
         end
         step();
      end
      check({tag, " busy after"}, 32'(busy), 32'd0);
      check({tag, " quotient held"}, quotient, eq);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;
`ifdef MD_DIV_CANCEL_EN
      cancel    = 1'b0;
`endif
      step();
      step();
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset quotient", quotient, 32'd0);
      check("reset remainder", remainder, 32'd0);
      check("reset dbz", 32'(div_by_zero), 32'd0);
      reset = 1'b0;
      step();

      run_div("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      run_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      run_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
      run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
      run_div("uFFFF/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
      run_div("u5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
      run_div("s5/0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
      run_div("s-5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
      run_div("u9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

      // start during CALC (cycle 10) and during DONE (cycle 34) must both be ignored
      is_signed = 1'b0;
      dividend  = 32'd100;
      divisor   = 32'd7;
      start     = 1'b1;
      step();
      for (int c = 1; c <= 34; c++) begin
         if (c == 10) begin
            start = 1'b1; is_signed = 1'b1; dividend = 32'd50; divisor = 32'd5;
         end else if (c == 34) begin
            start = 1'b1; is_signed = 1'b1; dividend = 32'd40; divisor = 32'd4;
         end else begin
            start = 1'b0;
         end
         check($sformatf("ign done c%0d", c), 32'(done), 32'(c == 34));
         step();
         if (c == 33) begin
            check("ign quotient", quotient, 32'd14);
            check("ign remainder", remainder, 32'd2);
         end
      end
      start = 1'b0;
      check("ign busy after done-start", 32'(busy), 32'd0);
      check("ign quotient held", quotient, 32'd14);

      // reset at cycle 20 aborts without done and clears the outputs
      dividend = 32'd200;
      divisor  = 32'd9;
      start    = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (c == 20) reset = 1'b1;
         check($sformatf("rst done c%0d", c), 32'(done), 32'd0);
         step();
      end
      reset = 1'b0;
      check("rst busy c21", 32'(busy), 32'd0);
      check("rst done c21", 32'(done), 32'd0);
      check("rst quotient", quotient, 32'd0);
      check("rst remainder", remainder, 32'd0);
      check("rst dbz", 32'(div_by_zero), 32'd0);
      for (int c = 22; c <= 40; c++) begin
         step();
         check($sformatf("rst no done c%0d", c), 32'(done), 32'd0);
      end

      // reset and start together in IDLE: reset wins
      reset = 1'b1;
      start = 1'b1;
      step();
      reset = 1'b0;
      start = 1'b0;
      check("rst_prio busy", 32'(busy), 32'd0);
      step();

      run_div("u9/3 after rst", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

`ifdef MD_DIV_CANCEL_EN
      is_signed = 1'b0;
      dividend  = 32'd100;
      divisor   = 32'd7;
      start     = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         if (c == 15) cancel = 1'b1;
         check($sformatf("cxl busy c%0d", c), 32'(busy), 32'd1);
         step();
      end
      check("cxl busy c16", 32'(busy), 32'd0);
      check("cxl done c16", 32'(done), 32'd0);
      check("cxl quotient held", quotient, 32'd3);
      check("cxl remainder held", remainder, 32'd0);
      // cancel stays high alongside the new start: start wins in IDLE
      dividend = 32'd200;
      divisor  = 32'd9;
      start    = 1'b1;
      step();
      start  = 1'b0;
      cancel = 1'b0;
      for (int c = 17; c <= 50; c++) begin
         check($sformatf("cxl2 done c%0d", c), 32'(done), 32'(c == 50));
         if (c == 50) begin
            check("cxl2 quotient", quotient, 32'd22);
            check("cxl2 remainder", remainder, 32'd2);
         end
         step();
      end
      check("cxl2 busy after", 32'(busy), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/md_divider.md
# md_divider

Iterative radix-2 restoring divider for the execute-stage multiply/divide path. It replaces the single-cycle behavioural `/` and `%` in front of the HI/LO register block. It latches operands on a `start` pulse, runs one quotient bit per cycle, and presents quotient (LO) and remainder (HI) with a one-cycle `done` pulse. The HI/LO block captures the result on `done`, and the pipeline stall logic uses `busy`.

## Interface
Parameters:
- `WIDTH`, default 32: operand, quotient and remainder width.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a division. Sampled only in IDLE.
- `is_signed`, in, 1: 1 selects DIV, 0 selects DIVU. Sampled with `start`.
- `dividend`, in, WIDTH: srcA. Sampled with `start`.
- `divisor`, in, WIDTH: srcB. Sampled with `start`.
- `cancel`, in, 1: abort the operation in flight. Present only with `MD_DIV_CANCEL_EN`.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `done`, out, 1: one-cycle pulse; result valid in the same cycle.
- `quotient`, out, WIDTH: LO value.
- `remainder`, out, WIDTH: HI value.
- `div_by_zero`, out, 1: the last completed operation had divisor 0.

## Operation
- States:
  - IDLE
  - CALC: WIDTH cycles, iteration counter 0..WIDTH-1.
  - FIX: 1 cycle.
  - DONE: 1 cycle.
- IDLE with `start`=1:
  - Latch `is_signed`.
  - Latch the magnitudes of `dividend` and `divisor`; magnitudes apply only if `is_signed` and the MSB is set.
  - Latch the dividend sign and the quotient sign (dividend sign XOR divisor sign).
  - Clear the partial remainder and the counter; go to CALC.
- CALC, each cycle:
  - Form `{rem, q}` shifted left by 1.
  - Compute trial = rem − |divisor| at WIDTH+1 bits.
  - If the trial is non-negative, rem ← trial and the q LSB ← 1.
  - The counter increments; at WIDTH-1 go to FIX.
- FIX:
  - Negate the quotient if the quotient sign is set and the operation is signed.
  - Negate the remainder if the dividend was negative and the operation is signed.
  - If the divisor was zero, override: quotient = all ones, remainder = the original dividend (raw bits), `div_by_zero`=1. Otherwise `div_by_zero`=0.
  - Register the results into the output regs; go to DONE.
- DONE: `done`=1, then go to IDLE.
- Outputs hold the last result until the next FIX.
- Signed overflow (`0x80000000` / −1): quotient = `0x80000000`, remainder = 0. This falls out of the magnitude arithmetic and needs no special case.
- `start` while `busy` is ignored, including in the DONE cycle.
- `start` is accepted in the cycle immediately after DONE.
- Operand inputs are don't-care after the start cycle.

## Timing
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, state = IDLE.
- Cycle map, with the start edge as cycle 0:
  - CALC in cycles 1..WIDTH.
  - FIX in cycle WIDTH+1.
  - DONE in cycle WIDTH+2, which is 34 for WIDTH=32.
- `busy` is high in cycles 1..WIDTH+2.
- Throughput: one division per WIDTH+3 cycles.
- `reset` mid-operation: IDLE on the next edge, no `done`, outputs return to 0.
- `reset` has priority over `start` and `cancel`.

## Configuration
- `MD_DIV_CANCEL_EN` defined:
  - The `cancel` port exists.
  - `cancel`=1 in CALC or FIX forces IDLE on the next edge; `done` is not asserted and the outputs keep their previous values.
  - `cancel` in IDLE or DONE has no effect.
  - `cancel` and `start` in the same IDLE cycle: `start` wins.
  - Used for exception flush.
- `MD_DIV_CANCEL_EN` undefined: no `cancel` port; an operation, once started, always completes.

## Structure
- Shared macro/package file holds:
  - the state encodings `DIVST_IDLE`, `DIVST_CALC`, `DIVST_FIX`, `DIVST_DONE`;
  - the default WIDTH;
  - the existing DIV/DIVU opcode macros, used by the instantiating stage to drive `is_signed`.
- One natural sub-module: `md_div_step`, a combinational single iteration, (rem, q, divisor) → (rem', q').
- The counter, FSM and sign fixup stay in `md_divider`.

## Test plan
- Unsigned 100 / 7 → quotient 14, remainder 2, `div_by_zero` 0, `done` exactly at cycle 34, `busy` high in cycles 1–34.
- Signed −7 (`0xFFFFFFF9`) / 2 → quotient `0xFFFFFFFD`, remainder `0xFFFFFFFF`. Signed 7 / −2 → quotient `0xFFFFFFFD`, remainder 1.
- Signed `0x80000000` / `0xFFFFFFFF` → quotient `0x80000000`, remainder 0. Unsigned `0xFFFFFFFF` / 1 → quotient `0xFFFFFFFF`, remainder 0.
- 5 / 0, both signed and unsigned → quotient `0xFFFFFFFF`, remainder 5, `div_by_zero` 1; the next 9 / 3 clears `div_by_zero` and gives 3 r 0.
- Second `start` with different operands at cycle 10 → ignored, first result unchanged. `reset` asserted at cycle 20 → `busy` 0 at cycle 21, no `done`, outputs 0.
- With `MD_DIV_CANCEL_EN`: `cancel` at cycle 15 → IDLE at 16, no `done`, previous outputs held. A new `start` at cycle 16 completes at cycle 50.
